// File: rtl/reg_file_pkg.sv
// Shared sizing for the architectural register file and its rename tags.
// A tag of zero marks a register as ready; ROB slots are numbered from 1.
package reg_file_pkg;

  localparam int unsigned RegNum = 32;
  localparam int unsigned TagW   = 5;
  localparam int unsigned XLen   = 32;

  localparam logic [TagW-1:0] TagReady = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// Operand lookup for one source register, forwarding a same-cycle commit
// that retires the pending writer.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned TAG_W = TagW,
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [XLen-1:0]  val_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             commit_valid_i,
  input  logic [REG_W-1:0] commit_rd_i,
  input  logic [XLen-1:0]  commit_res_i,
  input  logic [TAG_W-1:0] commit_dep_i,
  output logic [XLen-1:0]  val_o,
  output logic [TAG_W-1:0] dep_o
);

  always_comb begin
    val_o = val_i;
    dep_o = tag_i;
    if (rs_i == '0) begin
      val_o = '0;
      dep_o = '0;
    end else if (commit_valid_i && (commit_rd_i == rs_i) && (tag_i == commit_dep_i) &&
                 (tag_i != '0)) begin
      // Only forward when the commit retires the writer we are waiting on.
      val_o = commit_res_i;
      dep_o = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 32-bit values plus a pending ROB tag per register,
// updated by ROB commit, dispatcher rename and mispredict flush.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_NUM = RegNum,
  parameter int unsigned TAG_W   = TagW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy_i,
  input  logic                       flush_i,
  input  logic                       commit_valid_i,
  input  logic [$clog2(REG_NUM)-1:0] commit_rd_i,
  input  logic [XLen-1:0]            commit_res_i,
  input  logic [TAG_W-1:0]           commit_dependency_i,
  input  logic                       rename_valid_i,
  input  logic [$clog2(REG_NUM)-1:0] rename_rd_i,
  input  logic [TAG_W-1:0]           rename_tag_i,
  input  logic [$clog2(REG_NUM)-1:0] rs1_i,
  input  logic [$clog2(REG_NUM)-1:0] rs2_i,
  output logic [XLen-1:0]            rs1_val_o,
  output logic [XLen-1:0]            rs2_val_o,
  output logic [TAG_W-1:0]           rs1_dep_o,
  output logic [TAG_W-1:0]           rs2_dep_o
);

  localparam int unsigned RegW = $clog2(REG_NUM);

  logic [XLen-1:0]  val_q [REG_NUM];
  logic [XLen-1:0]  val_d [REG_NUM];
  logic [TAG_W-1:0] tag_q [REG_NUM];
  logic [TAG_W-1:0] tag_d [REG_NUM];

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (rdy_i) begin
      if (commit_valid_i && (commit_rd_i != '0)) begin
        val_d[commit_rd_i] = commit_res_i;
        if (tag_q[commit_rd_i] == commit_dependency_i) begin
          tag_d[commit_rd_i] = '0;
        end
      end
      // Flush drops every mapping; the commit value above still lands.
      if (flush_i) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          tag_d[i] = '0;
        end
      end else if (rename_valid_i && (rename_rd_i != '0)) begin
        tag_d[rename_rd_i] = rename_tag_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  reg_file_read_port #(
    .TAG_W(TAG_W),
    .REG_W(RegW)
  ) u_rs1_port (
    .rs_i          (rs1_i),
    .val_i         (val_q[rs1_i]),
    .tag_i         (tag_q[rs1_i]),
    .commit_valid_i(commit_valid_i),
    .commit_rd_i   (commit_rd_i),
    .commit_res_i  (commit_res_i),
    .commit_dep_i  (commit_dependency_i),
    .val_o         (rs1_val_o),
    .dep_o         (rs1_dep_o)
  );

  reg_file_read_port #(
    .TAG_W(TAG_W),
    .REG_W(RegW)
  ) u_rs2_port (
    .rs_i          (rs2_i),
    .val_i         (val_q[rs2_i]),
    .tag_i         (tag_q[rs2_i]),
    .commit_valid_i(commit_valid_i),
    .commit_rd_i   (commit_rd_i),
    .commit_res_i  (commit_res_i),
    .commit_dep_i  (commit_dependency_i),
    .val_o         (rs2_val_o),
    .dep_o         (rs2_dep_o)
  );

endmodule
